hazard_unit: RTL and testbench

Stall-side hazard unit for the 5-stage RV32I pipeline. It produces the `stall` signal that flush control consumes; flush control gates its branch flushes with `!stall`.
- Detects load-use hazards between ID and EX and inserts a single bubble.
- Freezes the whole pipeline while a load waits on a multi-cycle data memory, using a small FSM and a down-counter.
- Drives the PC and pipeline-register write enables and the ID/EX bubble select.

---
 rtl/hazard_unit.sv | 125 ++++++++++++
 tb/tb_hazard_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Stall-side hazard unit: load-use bubble insertion and multi-cycle load freeze.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_unit #(
    parameter int MEM_LAT = 2,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    input  logic             mem_read_mem,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      load_use_events
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam bit       HAS_LAT  = (MEM_LAT > 0);
    localparam bit       ONE_LAT  = (MEM_LAT == 1);
    localparam logic [3:0] CNT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_start;
    logic       freeze;
    logic       lu;
    logic       rs1_hit;
    logic       rs2_hit;

    // RELEASE is excluded so the load just served cannot retrigger a freeze.
    assign mem_start = (state_q == IDLE) && mem_read_mem && HAS_LAT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_start) begin
                    if (ONE_LAT) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gating with rst_n lets stall drop the instant reset is asserted.
    always_comb begin
        rs1_hit = use_rs1_id && (rs1_id == rd_ex);
        rs2_hit = use_rs2_id && (rs2_id == rd_ex);
        lu      = rst_n && mem_read_ex && (rd_ex != '0) && (rs1_hit || rs2_hit);
        freeze  = rst_n && (mem_start || (state_q == WAIT));
    end

    assign stall        = freeze || lu;
    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = lu && !freeze;
    assign ex_mem_write = !freeze;
    assign mem_wb_write = !freeze;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] load_use_events_q, load_use_events_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d    = stall_cycles_q + {31'd0, stall};
        load_use_events_d = load_use_events_q + {31'd0, id_ex_bubble};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q    <= 32'd0;
            load_use_events_q <= 32'd0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            load_use_events_q <= load_use_events_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign load_use_events = load_use_events_q;
`else
    assign stall_cycles    = 32'd0;
    assign load_use_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: five instances (MEM_LAT 0..4) share one stimulus stream
// and are compared against a cycle-indexed reference model of the hazard rules.
module tb_hazard_unit;

    localparam int N = 5;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       use_rs1_id, use_rs2_id, mem_read_ex, mem_read_mem;

    logic        stall_o [N];
    logic        pc_o    [N];
    logic        ifid_o  [N];
    logic        bub_o   [N];
    logic        exm_o   [N];
    logic        mwb_o   [N];
    logic [31:0] sc_o    [N];
    logic [31:0] lue_o   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        hazard_unit #(.MEM_LAT(g), .REG_W(5)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .rs1_id          (rs1_id),
            .rs2_id          (rs2_id),
            .use_rs1_id      (use_rs1_id),
            .use_rs2_id      (use_rs2_id),
            .rd_ex           (rd_ex),
            .mem_read_ex     (mem_read_ex),
            .mem_read_mem    (mem_read_mem),
            .stall           (stall_o[g]),
            .pc_write        (pc_o[g]),
            .if_id_write     (ifid_o[g]),
            .id_ex_bubble    (bub_o[g]),
            .ex_mem_write    (exm_o[g]),
            .mem_wb_write    (mwb_o[g]),
            .stall_cycles    (sc_o[g]),
            .load_use_events (lue_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a freeze that began at cycle fs covers cycles fs..fs+L-1,
    // cycle fs+L is the release cycle, and the unit is idle otherwise.
    int          cyc;
    int          fs      [N];
    logic [31:0] m_sc    [N];
    logic [31:0] m_lue   [N];
    bit          e_stall [N];
    bit          e_bub   [N];
    bit          e_start [N];
    int          checks;
    int          failures;

    task automatic chk(input string tag, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s[lat%0d] observed=%0h expected=%0h", tag, idx, got, exp);
        end
    endtask

    function automatic bit ref_lu();
        if (!rst_n || !mem_read_ex || rd_ex == 5'd0) return 1'b0;
        return (use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex);
    endfunction

    task automatic check_all();
        bit lu, in_frz, in_rel, frz;
        lu = ref_lu();
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                fs[i]    = -1;
                m_sc[i]  = 32'd0;
                m_lue[i] = 32'd0;
            end
            in_frz     = (fs[i] >= 0) && (cyc < fs[i] + i);
            in_rel     = (fs[i] >= 0) && (cyc == fs[i] + i);
            e_start[i] = rst_n && !in_frz && !in_rel && mem_read_mem && (i > 0);
            frz        = in_frz || e_start[i];
            e_stall[i] = frz || lu;
            e_bub[i]   = lu && !frz;
            chk("stall", i, {31'd0, stall_o[i]}, {31'd0, e_stall[i]});
            chk("pc_write", i, {31'd0, pc_o[i]}, {31'd0, !e_stall[i]});
            chk("if_id_write", i, {31'd0, ifid_o[i]}, {31'd0, !e_stall[i]});
            chk("id_ex_bubble", i, {31'd0, bub_o[i]}, {31'd0, e_bub[i]});
            chk("ex_mem_write", i, {31'd0, exm_o[i]}, {31'd0, !frz});
            chk("mem_wb_write", i, {31'd0, mwb_o[i]}, {31'd0, !frz});
`ifdef HAZARD_PERF_EN
            chk("stall_cycles", i, sc_o[i], m_sc[i]);
            chk("load_use_events", i, lue_o[i], m_lue[i]);
`else
            chk("stall_cycles", i, sc_o[i], 32'd0);
            chk("load_use_events", i, lue_o[i], 32'd0);
`endif
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < N; i++) begin
            if (rst_n) begin
                if (e_start[i]) fs[i] = cyc;
                if (e_stall[i]) m_sc[i] = m_sc[i] + 32'd1;
                if (e_bub[i])   m_lue[i] = m_lue[i] + 32'd1;
            end
        end
        cyc++;
    endtask

    // Called 1 time unit after a rising edge with inputs already applied.
    task automatic cycle();
        #3;
        check_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic set_in(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic mer,
                          input logic mrm);
        rs1_id       = r1;
        use_rs1_id   = u1;
        rs2_id       = r2;
        use_rs2_id   = u2;
        rd_ex        = rd;
        mem_read_ex  = mer;
        mem_read_mem = mrm;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int i = 0; i < N; i++) begin
            fs[i]    = -1;
            m_sc[i]  = 32'd0;
            m_lue[i] = 32'd0;
        end

        // Reset held with hazardous inputs: outputs must stay benign.
        rst_n = 1'b0;
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle();

        // Single load-use bubble, then the load moves on.
        set_in(5'd5, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        set_in(5'd5, 1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0);
        cycle();

        // x0 destination and unused rs2 are never hazards.
        set_in(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        cycle();
        set_in(5'd1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);
        cycle();
        set_in(5'd2, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
        cycle();

        // Long load held in MEM: each instance freezes MEM_LAT then releases.
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        repeat (6) cycle();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) cycle();

        // Load-use overlapping a freeze: bubble only outside the freeze.
        set_in(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        repeat (4) cycle();
        set_in(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        cycle();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (6) cycle();

        // Reset asserted part-way through a freeze, then a fresh full freeze.
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (7) cycle();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) cycle();

        // Randomised traffic with small register indices to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            set_in(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0));
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (6) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
